// File: rtl/ddr_pkg.sv
// Shared command/error encodings and default timing for the single-bank DDR responder.
package ddr_pkg;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_READ      = 3'd1,
        CMD_WRITE     = 3'd2,
        CMD_PRECHARGE = 3'd3,
        CMD_ACTIVATE  = 3'd4,
        CMD_REFRESH   = 3'd5
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_NO_ROW       = 3'd1,
        ERR_TRCD         = 3'd2,
        ERR_ROW_OPEN     = 3'd3,
        ERR_WR_NODATA    = 3'd4,
        ERR_TRFC         = 3'd5,
        ERR_REF_LATE     = 3'd6,
        ERR_BUS_CONFLICT = 3'd7
    } err_e;

    // The 3-bit code space is full, so an unknown command is reported as err high with code 0.
    localparam err_e ERR_BAD_CMD = ERR_NONE;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ACTIVE     = 2'd1,
        ST_REFRESHING = 2'd2
    } state_e;

    localparam int DEF_ROW_BITS = 4;
    localparam int DEF_COL_BITS = 12;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_CL       = 3;
    localparam int DEF_T_RCD    = 5;
    localparam int DEF_T_RFC    = 4;
    localparam int DEF_REF_MAX  = 700;

    function automatic logic cmd_is_known(input logic [2:0] c);
        return c <= 3'd5;
    endfunction

endpackage

// File: rtl/ddr_read_pipe.sv
// Reset-clearable valid+data delay line carrying read data towards the dq bus.
module ddr_read_pipe #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]  valid_reg;
    logic [DATA_W-1:0] data_reg [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_reg[i] <= 1'b0;
                data_reg[i]  <= '0;
            end
        end else begin
            valid_reg[0] <= in_valid;
            // Idle slots carry zero so dq_out only ever shows real read data.
            data_reg[0]  <= in_valid ? in_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                data_reg[i]  <= data_reg[i-1];
            end
        end
    end

    assign out_valid = valid_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];

endmodule

// File: rtl/ddr_mem_responder.sv
// Cycle-accurate single-bank DDR device model: decodes controller commands, stores data,
// returns reads after CL cycles and flags protocol timing/sequencing violations.
module ddr_mem_responder
    import ddr_pkg::*;
#(
    parameter int ROW_BITS = DEF_ROW_BITS,
    parameter int COL_BITS = DEF_COL_BITS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CL       = DEF_CL,
    parameter int T_RCD    = DEF_T_RCD,
    parameter int T_RFC    = DEF_T_RFC,
    parameter int REF_MAX  = DEF_REF_MAX
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs_n,
    input  logic [2:0]          cmd,
    input  logic [ROW_BITS-1:0] ra,
    input  logic [COL_BITS-1:0] ca,
    input  logic                r_w_enable,
    input  logic [DATA_W-1:0]   dq_in,
    output logic [DATA_W-1:0]   dq_out,
    output logic                dq_oe,
    output logic                row_open,
    output logic [ROW_BITS-1:0] open_row,
    output logic                err,
    output logic [2:0]          err_code
);

    localparam int ADDR_W = ROW_BITS + COL_BITS;
    localparam int RCD_W  = $clog2(T_RCD + 1);
    localparam int RFC_W  = $clog2(T_RFC + 1);
    localparam int REF_W  = $clog2(REF_MAX + 1);

    state_e              state_reg;
    logic [RCD_W-1:0]    rcd_cnt_reg;
    logic [RFC_W-1:0]    rfc_cnt_reg;
    logic [REF_W-1:0]    ref_timer_reg;
    logic [ROW_BITS-1:0] open_row_reg;
    logic                row_open_reg;
    logic                err_reg;
    err_e                err_code_reg;
    logic                rd_valid_reg;
    logic [DATA_W-1:0]   rd_data_reg;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    cmd_e              cmd_dec;
    logic              bad_cmd;
    logic              rcd_ok;
    logic              refresh_ok;
    logic              ref_late;
    logic              bus_conflict;
    logic              cmd_err_valid;
    err_e              cmd_err;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] mem_addr;

    always_comb begin
        cmd_dec = CMD_NOP;
        bad_cmd = 1'b0;
        if (!cs_n) begin
            if (cmd_is_known(cmd)) begin
                cmd_dec = cmd_e'(cmd);
            end else begin
                bad_cmd = 1'b1;
            end
        end
    end

    assign rcd_ok       = rcd_cnt_reg >= RCD_W'(T_RCD - 1);
    assign refresh_ok   = (state_reg == ST_IDLE) && (cmd_dec == CMD_REFRESH);
    assign ref_late     = (ref_timer_reg == REF_W'(REF_MAX - 1)) && !refresh_ok;
    assign bus_conflict = dq_oe && !r_w_enable;
    assign mem_addr     = {open_row_reg, ca};

    always_comb begin
        cmd_err_valid = 1'b0;
        cmd_err       = ERR_NONE;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        if (bad_cmd) begin
            cmd_err_valid = 1'b1;
            cmd_err       = ERR_BAD_CMD;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_dec == CMD_READ || cmd_dec == CMD_WRITE) begin
                        cmd_err_valid = 1'b1;
                        cmd_err       = ERR_NO_ROW;
                    end
                end
                ST_ACTIVE: begin
                    case (cmd_dec)
                        CMD_READ, CMD_WRITE: begin
                            if (!rcd_ok) begin
                                cmd_err_valid = 1'b1;
                                cmd_err       = ERR_TRCD;
                            end else if (cmd_dec == CMD_WRITE && r_w_enable) begin
                                cmd_err_valid = 1'b1;
                                cmd_err       = ERR_WR_NODATA;
                            end else if (cmd_dec == CMD_WRITE) begin
                                wr_en = 1'b1;
                            end else begin
                                rd_en = 1'b1;
                            end
                        end
                        CMD_ACTIVATE, CMD_REFRESH: begin
                            cmd_err_valid = 1'b1;
                            cmd_err       = ERR_ROW_OPEN;
                        end
                        default: ;
                    endcase
                end
                ST_REFRESHING: begin
                    if (cmd_dec != CMD_NOP) begin
                        cmd_err_valid = 1'b1;
                        cmd_err       = ERR_TRFC;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain; the registered read is CAS stage one.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[mem_addr] <= dq_in;
        end
        rd_data_reg <= mem[mem_addr];
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg     <= ST_IDLE;
            rcd_cnt_reg   <= '0;
            rfc_cnt_reg   <= '0;
            ref_timer_reg <= '0;
            open_row_reg  <= '0;
            row_open_reg  <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
            rd_valid_reg  <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
            err_reg      <= bus_conflict | ref_late | cmd_err_valid;
            if (bus_conflict) begin
                err_code_reg <= ERR_BUS_CONFLICT;
            end else if (ref_late) begin
                err_code_reg <= ERR_REF_LATE;
            end else if (cmd_err_valid) begin
                err_code_reg <= cmd_err;
            end

            if (refresh_ok) begin
                ref_timer_reg <= '0;
            end else if (ref_timer_reg != REF_W'(REF_MAX)) begin
                ref_timer_reg <= ref_timer_reg + 1'b1;
            end

            if (rcd_cnt_reg != RCD_W'(T_RCD)) begin
                rcd_cnt_reg <= rcd_cnt_reg + 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cmd_dec == CMD_ACTIVATE) begin
                        open_row_reg <= ra;
                        row_open_reg <= 1'b1;
                        rcd_cnt_reg  <= '0;
                        state_reg    <= ST_ACTIVE;
                    end else if (cmd_dec == CMD_REFRESH) begin
                        rfc_cnt_reg <= '0;
                        state_reg   <= ST_REFRESHING;
                    end
                end
                ST_ACTIVE: begin
                    if (cmd_dec == CMD_PRECHARGE) begin
                        row_open_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end
                ST_REFRESHING: begin
                    if (rfc_cnt_reg == RFC_W'(T_RFC - 1)) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        rfc_cnt_reg <= rfc_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // CL counts the RAM read register plus CL-1 pipe stages, so CL must be at least 2.
    ddr_read_pipe #(
        .DEPTH  (CL - 1),
        .DATA_W (DATA_W)
    ) u_read_pipe (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (rd_valid_reg),
        .in_data   (rd_data_reg),
        .out_valid (dq_oe),
        .out_data  (dq_out)
    );

    assign row_open = row_open_reg;
    assign open_row = open_row_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;

endmodule

// File: tb/tb_ddr_mem_responder.sv
// Directed bench for ddr_mem_responder: hand-computed expectations, sampled on the falling edge.
`timescale 1ns/1ps
module tb_ddr_mem_responder;
    import ddr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cs_n = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic [3:0]  ra = '0;
    logic [11:0] ca = '0;
    logic        r_w_enable = 1'b1;
    logic [31:0] dq_in = '0;
    logic [31:0] dq_out;
    logic        dq_oe;
    logic        row_open;
    logic [3:0]  open_row;
    logic        err;
    logic [2:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int oe_cnt = 0;
    int first_err = 0;
    logic [2:0] code_seen = '0;

    ddr_mem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .cmd        (cmd),
        .ra         (ra),
        .ca         (ca),
        .r_w_enable (r_w_enable),
        .dq_in      (dq_in),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe),
        .row_open   (row_open),
        .open_row   (open_row),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("  ok   %s = %08h", tag, got);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (err) err_cnt++;
        if (dq_oe) oe_cnt++;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cmd_cycle(input logic [2:0] c, input logic [3:0] r, input logic [11:0] a,
                             input logic rwe, input logic [31:0] d);
        cmd = c; ra = r; ca = a; r_w_enable = rwe; dq_in = d;
        $display("cmd %0d cs_n=%0b ra=%0h ca=%03h rwe=%0b dq_in=%08h", c, cs_n, r, a, rwe, d);
        step();
        cmd = CMD_NOP; r_w_enable = 1'b1; cs_n = 1'b0;
    endtask

    task automatic do_reset();
        cs_n = 1'b0; cmd = CMD_NOP; ra = '0; ca = '0; r_w_enable = 1'b1; dq_in = '0;
        rst_n = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        err_cnt = 0;
        oe_cnt = 0;
    endtask

    initial begin
        // Reset values
        do_reset();
        check_value("rst_dq_out", dq_out, 32'h0);
        check_value("rst_dq_oe", 32'(dq_oe), 32'd0);
        check_value("rst_row_open", 32'(row_open), 32'd0);
        check_value("rst_open_row", 32'(open_row), 32'd0);
        check_value("rst_err", 32'(err), 32'd0);
        check_value("rst_err_code", 32'(err_code), 32'd0);

        // Write then read in the same row; WRITE exactly T_RCD cycles after ACTIVATE is legal
        cmd_cycle(CMD_ACTIVATE, 4'd3, 12'h000, 1'b1, 32'h0);
        check_value("act_row_open", 32'(row_open), 32'd1);
        check_value("act_open_row", 32'(open_row), 32'd3);
        nops(4);
        cmd_cycle(CMD_WRITE, 4'd0, 12'h010, 1'b0, 32'hDEADBEEF);
        nops(3);
        cmd_cycle(CMD_READ, 4'd0, 12'h010, 1'b1, 32'h0);
        check_value("rd_oe_t1", 32'(dq_oe), 32'd0);
        step();
        check_value("rd_oe_t2", 32'(dq_oe), 32'd0);
        step();
        check_value("rd_oe_t3", 32'(dq_oe), 32'd1);
        check_value("rd_data_t3", dq_out, 32'hDEADBEEF);
        step();
        check_value("rd_oe_t4", 32'(dq_oe), 32'd0);
        check_value("wr_rd_no_err", 32'(err_cnt), 32'd0);

        // tRCD violations: READ 2 and 4 cycles after ACTIVATE
        do_reset();
        cmd_cycle(CMD_ACTIVATE, 4'd1, 12'h000, 1'b1, 32'h0);
        nops(1);
        cmd_cycle(CMD_READ, 4'd0, 12'h000, 1'b1, 32'h0);
        check_value("trcd_err", 32'(err), 32'd1);
        check_value("trcd_code", 32'(err_code), 32'(ERR_TRCD));
        cmd_cycle(CMD_PRECHARGE, 4'd0, 12'h000, 1'b1, 32'h0);
        cmd_cycle(CMD_ACTIVATE, 4'd1, 12'h000, 1'b1, 32'h0);
        nops(3);
        cmd_cycle(CMD_READ, 4'd0, 12'h000, 1'b1, 32'h0);
        check_value("trcd4_err", 32'(err), 32'd1);
        check_value("trcd4_code", 32'(err_code), 32'(ERR_TRCD));
        nops(4);
        check_value("trcd_no_oe", 32'(oe_cnt), 32'd0);

        // Row change: preload rows 5 and 2, switch back to row 5
        do_reset();
        cmd_cycle(CMD_ACTIVATE, 4'd5, 12'h000, 1'b1, 32'h0);
        nops(4);
        cmd_cycle(CMD_WRITE, 4'd0, 12'h000, 1'b0, 32'h5A5A0000);
        cmd_cycle(CMD_PRECHARGE, 4'd0, 12'h000, 1'b1, 32'h0);
        cmd_cycle(CMD_ACTIVATE, 4'd2, 12'h000, 1'b1, 32'h0);
        nops(4);
        cmd_cycle(CMD_WRITE, 4'd0, 12'h000, 1'b0, 32'h22220000);
        cmd_cycle(CMD_PRECHARGE, 4'd0, 12'h000, 1'b1, 32'h0);
        check_value("pre_row_open", 32'(row_open), 32'd0);
        cmd_cycle(CMD_ACTIVATE, 4'd5, 12'h000, 1'b1, 32'h0);
        check_value("chg_open_row", 32'(open_row), 32'd5);
        nops(4);
        cmd_cycle(CMD_READ, 4'd0, 12'h000, 1'b1, 32'h0);
        nops(2);
        check_value("chg_oe", 32'(dq_oe), 32'd1);
        check_value("chg_data", dq_out, 32'h5A5A0000);
        cmd_cycle(CMD_ACTIVATE, 4'd7, 12'h000, 1'b1, 32'h0);
        check_value("rowopen_err", 32'(err), 32'd1);
        check_value("rowopen_code", 32'(err_code), 32'(ERR_ROW_OPEN));
        check_value("rowopen_keep", 32'(open_row), 32'd5);

        // Refresh: only NOP legal for T_RFC cycles
        do_reset();
        cmd_cycle(CMD_PRECHARGE, 4'd0, 12'h000, 1'b1, 32'h0);
        check_value("idle_pre_ok", 32'(err), 32'd0);
        cmd_cycle(CMD_REFRESH, 4'd0, 12'h000, 1'b1, 32'h0);
        cmd_cycle(CMD_READ, 4'd0, 12'h000, 1'b1, 32'h0);
        check_value("trfc_err", 32'(err), 32'd1);
        check_value("trfc_code", 32'(err_code), 32'(ERR_TRFC));
        nops(2);
        cmd_cycle(CMD_ACTIVATE, 4'd6, 12'h000, 1'b1, 32'h0);
        check_value("trfc_last_code", 32'(err_code), 32'(ERR_TRFC));
        check_value("trfc_last_row", 32'(row_open), 32'd0);
        cmd_cycle(CMD_ACTIVATE, 4'd6, 12'h000, 1'b1, 32'h0);
        check_value("post_rfc_err", 32'(err), 32'd0);
        check_value("post_rfc_row", 32'(row_open), 32'd1);

        // Refresh watchdog: one REF_LATE pulse REF_MAX cycles after reset
        do_reset();
        first_err = 0;
        for (int i = 1; i <= 760; i++) begin
            step();
            if (err && first_err == 0) begin
                first_err = i;
                code_seen = err_code;
            end
        end
        check_value("ref_late_cycle", 32'(first_err), 32'd700);
        check_value("ref_late_code", 32'(code_seen), 32'(ERR_REF_LATE));
        check_value("ref_late_pulses", 32'(err_cnt), 32'd1);
        cmd_cycle(CMD_REFRESH, 4'd0, 12'h000, 1'b1, 32'h0);
        check_value("refresh_ok", 32'(err), 32'd0);

        // Back-to-back reads, then the same with reset mid-flight
        do_reset();
        cmd_cycle(CMD_ACTIVATE, 4'd0, 12'h000, 1'b1, 32'h0);
        nops(4);
        cmd_cycle(CMD_WRITE, 4'd0, 12'h001, 1'b0, 32'h11111111);
        cmd_cycle(CMD_WRITE, 4'd0, 12'h002, 1'b0, 32'h22222222);
        cmd_cycle(CMD_READ, 4'd0, 12'h001, 1'b1, 32'h0);
        cmd_cycle(CMD_READ, 4'd0, 12'h002, 1'b1, 32'h0);
        step();
        check_value("b2b_oe_t3", 32'(dq_oe), 32'd1);
        check_value("b2b_data_t3", dq_out, 32'h11111111);
        step();
        check_value("b2b_oe_t4", 32'(dq_oe), 32'd1);
        check_value("b2b_data_t4", dq_out, 32'h22222222);
        step();
        check_value("b2b_oe_t5", 32'(dq_oe), 32'd0);
        cmd_cycle(CMD_READ, 4'd0, 12'h001, 1'b1, 32'h0);
        cmd_cycle(CMD_READ, 4'd0, 12'h002, 1'b1, 32'h0);
        rst_n = 1'b1;
        oe_cnt = 0;
        step();
        step();
        check_value("rst_mid_oe", 32'(oe_cnt), 32'd0);
        check_value("rst_mid_row", 32'(row_open), 32'd0);
        rst_n = 1'b0;

        // Write without data, bus conflict, unknown command, deselected chip
        do_reset();
        cmd_cycle(CMD_ACTIVATE, 4'd4, 12'h000, 1'b1, 32'h0);
        nops(4);
        cmd_cycle(CMD_WRITE, 4'd0, 12'h007, 1'b0, 32'hCAFEF00D);
        check_value("wr_ok_err", 32'(err), 32'd0);
        cmd_cycle(CMD_WRITE, 4'd0, 12'h007, 1'b1, 32'h0BADBEEF);
        check_value("nodata_err", 32'(err), 32'd1);
        check_value("nodata_code", 32'(err_code), 32'(ERR_WR_NODATA));
        cmd_cycle(CMD_READ, 4'd0, 12'h007, 1'b1, 32'h0);
        nops(2);
        check_value("nodata_oe", 32'(dq_oe), 32'd1);
        check_value("nodata_mem", dq_out, 32'hCAFEF00D);
        cmd_cycle(CMD_WRITE, 4'd0, 12'h008, 1'b0, 32'h12345678);
        check_value("conflict_err", 32'(err), 32'd1);
        check_value("conflict_code", 32'(err_code), 32'(ERR_BUS_CONFLICT));
        cmd_cycle(CMD_READ, 4'd0, 12'h008, 1'b1, 32'h0);
        nops(2);
        check_value("conflict_wrote", dq_out, 32'h12345678);
        cmd_cycle(3'd7, 4'd0, 12'h000, 1'b1, 32'h0);
        check_value("badcmd_err", 32'(err), 32'd1);
        check_value("badcmd_code", 32'(err_code), 32'(ERR_BAD_CMD));
        cs_n = 1'b1;
        cmd_cycle(3'd7, 4'd0, 12'h000, 1'b1, 32'h0);
        check_value("deselect_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr_mem_responder.md
Name: ddr_mem_responder

Overview:
- Memory-side end of the mem_intf command bus: a cycle-accurate single-bank DDR device model that decodes controller commands.
- Commands: NOP, READ, WRITE, PRECHARGE, ACTIVATE, REFRESH. Holds row/column storage and returns read data after CAS latency.
- Checks protocol timing and sequencing, and flags violations.
- Sits under the memory interface, opposite the FSM controller; used as the bench's DUT-facing memory and as a protocol checker.

Parameters:
ROW_BITS, 4, row address width (ra)
COL_BITS, 12, column address width (ca)
DATA_W, 32, dq width
CL, 3, read latency in cycles from READ command to data valid
T_RCD, 5, minimum cycles from ACTIVATE to READ/WRITE
T_RFC, 4, cycles after REFRESH during which only NOP is legal
REF_MAX, 700, maximum cycles between REFRESH commands before ref_err

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; asynchronous, active-high (asserted when 1)
cs_n  in  1  chip select, active-low; when 1, cmd is treated as NOP
cmd  in  3  command: 0 NOP, 1 READ, 2 WRITE, 3 PRECHARGE, 4 ACTIVATE, 5 REFRESH
ra  in  ROW_BITS  row address, sampled on ACTIVATE
ca  in  COL_BITS  column address, sampled on READ/WRITE
r_w_enable  in  1  0 = controller drives dq (write), 1 = controller releases dq
dq_in  in  DATA_W  write data from controller
dq_out  out  DATA_W  read data to controller
dq_oe  out  1  dq_out valid/driven; the bench resolves the shared dq from this
row_open  out  1  a row is currently active
open_row  out  ROW_BITS  currently active row
err  out  1  one-cycle pulse on any protocol violation
err_code  out  3  cause of err; holds the last code until the next err

Behaviour:
- Reset values: dq_out=0, dq_oe=0, row_open=0, open_row=0, err=0, err_code=0.
- Reset clears the read pipeline, all counters and the state.
- Reset does not clear the storage array.
- Reset mid-read: pending data is discarded and dq_oe stays 0.
- States:
  - IDLE: no row open.
  - ACTIVE: row open, tRCD counter runs.
  - REFRESHING: T_RFC countdown.
- IDLE:
  - ACTIVATE: open_row<=ra, row_open<=1, rcd_cnt<=0, go to ACTIVE.
  - REFRESH: go to REFRESHING, ref_cnt<=0.
  - READ or WRITE: err, code NO_ROW, no access.
  - PRECHARGE: legal no-op.
- ACTIVE:
  - rcd_cnt saturates at T_RCD.
  - READ/WRITE with rcd_cnt < T_RCD-1 (i.e. issued fewer than T_RCD cycles after ACTIVATE): err, code TRCD, access dropped.
  - PRECHARGE: row_open<=0, go to IDLE.
  - ACTIVATE: err, code ROW_OPEN; open_row is unchanged.
  - REFRESH: err, code ROW_OPEN; ignored.
- WRITE, legal case: requires r_w_enable==0 in the same cycle.
  - mem[{open_row,ca}]<=dq_in; write latency 0.
  - If r_w_enable==1: err, code WR_NODATA, no write.
- READ, legal case: push {1, mem[{open_row,ca}]} into the CL-deep pipeline.
  - Exactly CL cycles later: dq_oe=1 for one cycle, with dq_out=data.
  - Back-to-back READs give back-to-back data.
  - Data is sampled at command time: a WRITE to the same address before data returns does not alter it.
- REFRESHING:
  - Counts T_RFC cycles, then returns to IDLE.
  - Any non-NOP command during the countdown: err, code TRFC, ignored.
- Refresh watchdog:
  - Counts cycles since reset or since the last REFRESH, saturating.
  - On reaching REF_MAX: err, code REF_LATE, once per interval.
  - Cleared by REFRESH.
- Bus conflict: dq_oe==1 in the same cycle as r_w_enable==0 → err, code BUS_CONFLICT; the write still occurs.
- Priority when one cycle has several violations: BUS_CONFLICT > REF_LATE > command error.
- Unknown cmd values (6, 7): err, code BAD_CMD, treated as NOP.

Decomposition:
- Package ddr_pkg holds:
  - cmd_e enum: NOP, READ, WRITE, PRECHARGE, ACTIVATE, REFRESH.
  - err_e enum: NONE=0, NO_ROW, TRCD, ROW_OPEN, WR_NODATA, TRFC, REF_LATE, BUS_CONFLICT.
  - Default timing constants.
- Sub-module ddr_read_pipe: parameterised CL-deep valid+data shift register, reset-clearable.

Test Plan:
- Write then read, same row:
  - Stimulus: ACTIVATE ra=3; wait 5 cycles; WRITE ca=0x010, dq_in=0xDEADBEEF, r_w_enable=0; 3 NOPs; READ ca=0x010.
  - Required: dq_oe=1 with dq_out=0xDEADBEEF exactly 3 cycles after READ; err never asserted.
- tRCD violation:
  - Stimulus: ACTIVATE ra=1, then READ 2 cycles later.
  - Required: err=1 with err_code=TRCD; no dq_oe pulse.
- Row change:
  - Stimulus: row 2 open; PRECHARGE; ACTIVATE ra=5; wait 5; READ ca=0.
  - Required: open_row=5; data returned is from row 5 (preloaded 0x5A5A0000).
  - Follow-up: an ACTIVATE with no PRECHARGE gives err_code=ROW_OPEN.
- Refresh sequence:
  - Stimulus: PRECHARGE, REFRESH, READ 1 cycle later.
  - Required: err_code=TRFC.
  - Separately: with no REFRESH for 700 cycles, err_code=REF_LATE pulses once.
- Back-to-back reads with reset mid-flight:
  - Stimulus: READs at cycles t, t+1.
  - Required: dq_oe high at t+3 and t+4.
  - Repeat with rst_n=1 asserted at t+2: dq_oe stays 0 and row_open=0.
- Bus conflict and write without data:
  - Stimulus: WRITE with r_w_enable=1.
  - Required: WR_NODATA, memory unchanged.
  - Stimulus: WRITE in the cycle read data returns.
  - Required: BUS_CONFLICT.
